// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// This is the first pipeline stage, and it feeds decode. It owns the fetch PC
// and issues in-order word requests to instruction memory. Returned words go
// into a small FIFO, and the stage presents one {PC, instr} pair per cycle to
// decode. When decode stalls (hazard), the presented pair holds. A redirect
// from execute (pcWriteEnable) flushes everything buffered and discards every
// response still in flight.
//
// Ports
//   clk            pipeline clock, rising edge
//   reset          asynchronous reset, active low (0 = reset)
//   hazard         decode stall: hold PC / instr / instrValid
//   pcWriteEnable  redirect request from execute (overrides hazard)
//   pcWriteData    redirect target (forced to word alignment)
//   imemReqValid   request valid towards instruction memory
//   imemReqReady   memory accepts the request this cycle
//   imemReqAddr    word address requested
//   imemRspValid   response word valid (in order, one per accepted request)
//   imemRspData    response word
//   PC             PC of the instruction presented to decode
//   instr          instruction presented to decode (NOP when bubble)
//   instrValid     1 = real instruction, 0 = bubble
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0033
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        pcWriteEnable,
  input  logic [31:0] pcWriteData,
  output logic        imemReqValid,
  input  logic        imemReqReady,
  output logic [31:0] imemReqAddr,
  input  logic        imemRspValid,
  input  logic [31:0] imemRspData,
  output logic [31:0] PC,
  output logic [31:0] instr,
  output logic        instrValid
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);
  localparam logic [CW:0]   OCC_DEPTH = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  // Control state
  logic [31:0]   fetch_pc;
  logic [CW-1:0] outstanding;   // accepted requests whose response has not returned
  logic [CW-1:0] drop;          // in-flight responses that belong to a squashed path
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] fifo_rd;
  logic [AW-1:0] fifo_wr;
  logic [AW-1:0] pcq_rd;
  logic [AW-1:0] pcq_wr;

  // Data storage (no reset needed: contents are only read behind valid counts)
  logic [31:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];
  logic [31:0] pcq        [DEPTH];

  // Output register presented to decode
  logic [31:0] pc_p0;
  logic [31:0] instr_p0;
  logic        vld_p0;

  // Combinational control
  logic [CW:0] occupancy;
  logic        req_fire;
  logic        fifo_empty;
  logic        fifo_full;
  logic        rsp_keep;
  logic [31:0] rsp_pc;
  logic        advance;
  logic        pop;
  logic        bypass;
  logic        push;
  logic        unused_addr_bits;

  // The low two bits of a redirect target are forced to zero.
  assign unused_addr_bits = ^pcWriteData[1:0];

  // Buffered words plus outstanding requests never exceed DEPTH, so every
  // response always has a FIFO slot. That cap is what makes overflow impossible.
  assign occupancy    = {1'b0, fifo_count} + {1'b0, outstanding};
  assign imemReqValid = reset && !pcWriteEnable && (occupancy < OCC_DEPTH);
  assign imemReqAddr  = fetch_pc;
  assign req_fire     = imemReqValid && imemReqReady;

  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == CNT_DEPTH);

  // A response is kept only if it is not owed to a squashed path and it does
  // not collide with a redirect in the same cycle.
  assign rsp_keep = imemRspValid && (drop == '0) && !pcWriteEnable;
  assign rsp_pc   = pcq[pcq_rd];

  // A kept response goes straight to the output register when nothing older
  // is buffered and decode can take it. Otherwise it is queued.
  assign advance = !pcWriteEnable && !hazard;
  assign pop     = advance && !fifo_empty;
  assign bypass  = advance && fifo_empty && rsp_keep;
  assign push    = rsp_keep && !bypass;

  // ---- stage 0: fetch PC, request bookkeeping and FIFO control ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      pcq_rd      <= '0;
      pcq_wr      <= '0;
    end else begin
      // Fetch PC: a redirect wins. No request can be accepted in a redirect
      // cycle, because imemReqValid is low.
      if (pcWriteEnable) begin
        fetch_pc <= {pcWriteData[31:2], 2'b00};
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + 32'd4;
      end

      // Outstanding requests: an accept and a response in the same cycle cancel.
      unique case ({req_fire, imemRspValid})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase

      // On a redirect, every request still outstanding after this cycle
      // belongs to the old path. That count already includes any drops still
      // pending from an earlier redirect, so back-to-back redirects accumulate
      // without double counting.
      if (pcWriteEnable) begin
        drop <= outstanding - (imemRspValid ? CNT_ONE : '0);
      end else if (imemRspValid && (drop != '0)) begin
        drop <= drop - CNT_ONE;
      end

      // The PC queue mirrors the memory's in-order responses one to one,
      // including responses that end up discarded.
      if (req_fire) begin
        pcq_wr <= pcq_wr + PTR_ONE;
      end
      if (imemRspValid) begin
        pcq_rd <= pcq_rd + PTR_ONE;
      end

      // Instruction FIFO
      if (pcWriteEnable) begin
        fifo_count <= '0;
        fifo_rd    <= '0;
        fifo_wr    <= '0;
      end else begin
        if (push) begin
          fifo_wr <= fifo_wr + PTR_ONE;
        end
        if (pop) begin
          fifo_rd <= fifo_rd + PTR_ONE;
        end
        unique case ({push, pop})
          2'b10:   fifo_count <= fifo_count + CNT_ONE;
          2'b01:   fifo_count <= fifo_count - CNT_ONE;
          default: fifo_count <= fifo_count;
        endcase
      end
    end
  end

  // ---- stage 0 storage: PC queue and FIFO payload ----
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq[pcq_wr] <= fetch_pc;
    end
    if (push) begin
      fifo_pc[fifo_wr]    <= rsp_pc;
      fifo_instr[fifo_wr] <= imemRspData;
    end
  end

  // ---- stage 0 -> decode: output register ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_p0    <= RESET_PC;
      instr_p0 <= NOP;
      vld_p0   <= 1'b0;
    end else if (pcWriteEnable) begin
      // Redirect squashes the presented instruction even under a stall.
      // PC is left alone.
      instr_p0 <= NOP;
      vld_p0   <= 1'b0;
    end else if (!hazard) begin
      if (!fifo_empty) begin
        pc_p0    <= fifo_pc[fifo_rd];
        instr_p0 <= fifo_instr[fifo_rd];
        vld_p0   <= 1'b1;
      end else if (rsp_keep) begin
        pc_p0    <= rsp_pc;
        instr_p0 <= imemRspData;
        vld_p0   <= 1'b1;
      end else begin
        instr_p0 <= NOP;
        vld_p0   <= 1'b0;
      end
    end
  end

  assign PC         = pc_p0;
  assign instr      = instr_p0;
  assign instrValid = vld_p0;

  // Structural invariants of the occupancy cap
  fifo_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(push && fifo_full && !pop));
  pcq_no_overflow : assert property (@(posedge clk) disable iff (!reset)
    !(req_fire && (outstanding == CNT_DEPTH)));
  no_orphan_response : assert property (@(posedge clk) disable iff (!reset)
    !(imemRspValid && (outstanding == '0)));

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage. It holds an in-order instruction-memory model with a
// configurable latency, plus a behavioural reference of the fetch stage built
// from queues: in-flight requests carry a "squashed" flag, and buffered words
// sit in a queue. On every cycle, one compare process checks the DUT outputs
// against that reference. Directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0033;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hazard = 1'b0;
  logic        pcWriteEnable = 1'b0;
  logic [31:0] pcWriteData = 32'h0;
  logic        imemReqValid;
  logic        imemReqReady = 1'b1;
  logic [31:0] imemReqAddr;
  logic        imemRspValid = 1'b0;
  logic [31:0] imemRspData = 32'h0;
  logic [31:0] PC;
  logic [31:0] instr;
  logic        instrValid;

  fetch_stage #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .NOP      (NOP)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .hazard        (hazard),
    .pcWriteEnable (pcWriteEnable),
    .pcWriteData   (pcWriteData),
    .imemReqValid  (imemReqValid),
    .imemReqReady  (imemReqReady),
    .imemReqAddr   (imemReqAddr),
    .imemRspValid  (imemRspValid),
    .imemRspData   (imemRspData),
    .PC            (PC),
    .instr         (instr),
    .instrValid    (instrValid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Memory model
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mem_q[$];
  int    cyc = 0;
  int    mem_lat = 1;

  // Reference model
  typedef struct { logic [31:0] pc; bit squashed; } inflight_t;
  typedef struct { logic [31:0] pc; logic [31:0] word; } pair_t;
  inflight_t   m_inflight[$];
  pair_t       m_fifo[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_pc = RESET_PC;
  logic [31:0] m_instr = NOP;
  logic        m_vld = 1'b0;

  logic        s_req_valid = 1'b0;
  logic [31:0] s_req_addr = 32'h0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit m_req_valid();
    return reset && !pcWriteEnable && ((m_fifo.size() + m_inflight.size()) < DEPTH);
  endfunction

  // One clock edge of the reference stage, applied to the inputs of the cycle
  // that is ending.
  task automatic model_step();
    inflight_t h;
    pair_t     p;
    bit        keep;
    bit        acc;
    acc  = m_req_valid() && imemReqReady;
    keep = 0;
    h    = '{32'h0, 1'b0};
    if (imemRspValid && m_inflight.size() > 0) begin
      h    = m_inflight.pop_front();
      keep = !h.squashed && !pcWriteEnable;
    end
    if (pcWriteEnable) begin
      m_instr = NOP;
      m_vld   = 1'b0;
    end else if (!hazard) begin
      if (m_fifo.size() > 0) begin
        p       = m_fifo.pop_front();
        m_pc    = p.pc;
        m_instr = p.word;
        m_vld   = 1'b1;
      end else if (keep) begin
        m_pc    = h.pc;
        m_instr = imemRspData;
        m_vld   = 1'b1;
        keep    = 0;
      end else begin
        m_instr = NOP;
        m_vld   = 1'b0;
      end
    end
    if (keep) m_fifo.push_back('{h.pc, imemRspData});
    if (pcWriteEnable) begin
      m_fifo.delete();
      foreach (m_inflight[i]) m_inflight[i].squashed = 1'b1;
      m_fetch_pc = {pcWriteData[31:2], 2'b00};
    end else if (acc) begin
      m_inflight.push_back('{m_fetch_pc, 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
  endtask

  // Falling edge: drive the memory response, then compare against the model.
  always @(negedge clk) begin
    s_req_valid = imemReqValid;
    s_req_addr  = imemReqAddr;
    if (reset && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imemRspValid = 1'b1;
      imemRspData  = memf(mem_q[0].addr);
    end else begin
      imemRspValid = 1'b0;
      imemRspData  = 32'h0;
    end
    if (reset) begin
      check32("pc", PC, m_pc);
      check32("instr", instr, m_instr);
      check1("instr_valid", instrValid, m_vld);
      check1("req_valid", imemReqValid, m_req_valid());
      if (m_req_valid()) check32("req_addr", imemReqAddr, m_fetch_pc);
    end
  end

  // Rising edge: advance memory and reference model.
  always @(posedge clk) begin
    if (!reset) begin
      mem_q.delete();
      m_inflight.delete();
      m_fifo.delete();
      m_fetch_pc = RESET_PC;
      m_pc       = RESET_PC;
      m_instr    = NOP;
      m_vld      = 1'b0;
    end else begin
      model_step();
      if (imemRspValid && mem_q.size() > 0) void'(mem_q.pop_front());
      if (s_req_valid && imemReqReady) mem_q.push_back('{s_req_addr, cyc + mem_lat});
    end
    cyc++;
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (instrValid === 1'b1) break;
      step(1);
    end
    check1(name, instrValid, 1'b1);
  endtask

  task automatic do_reset(input int lat);
    reset   = 1'b0;
    mem_lat = lat;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    step(2);
    check32("rst_pc", PC, RESET_PC);
    check32("rst_instr", instr, 32'h0000_0033);
    check1("rst_instr_valid", instrValid, 1'b0);
    check1("rst_req_valid", imemReqValid, 1'b0);

    // Streaming with latency 1: first valid output two edges after release
    reset = 1'b1;
    step(2);
    check32("stream_pc0", PC, 32'h0);
    check32("stream_instr0", instr, 32'hDEAD_0000);
    check1("stream_vld0", instrValid, 1'b1);
    for (int i = 1; i < 8; i++) begin
      step(1);
      check32("stream_pc", PC, 32'(4 * i));
      check1("stream_vld", instrValid, 1'b1);
    end

    // Ready low for three cycles while 0x8 is requested
    do_reset(1);
    step(2);
    imemReqReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check1("stall_req_valid", imemReqValid, 1'b1);
      check32("stall_req_addr", imemReqAddr, 32'h8);
      step(1);
    end
    imemReqReady = 1'b1;
    check32("stall_bubble_instr", instr, NOP);
    check1("stall_bubble_vld", instrValid, 1'b0);
    step(2);
    check32("stall_resume_pc", PC, 32'h8);
    check32("stall_resume_instr", instr, memf(32'h8));

    // Decode hazard for two cycles while PC=0x4
    do_reset(1);
    step(3);
    check32("hz_pc_before", PC, 32'h4);
    hazard = 1'b1;
    step(1);
    check32("hz_hold_pc1", PC, 32'h4);
    check1("hz_hold_vld1", instrValid, 1'b1);
    step(1);
    check32("hz_hold_pc2", PC, 32'h4);
    check1("hz_fifo_full_no_req", imemReqValid, 1'b0);
    hazard = 1'b0;
    step(1);
    check32("hz_next_pc", PC, 32'h8);
    step(1);
    check32("hz_next_pc2", PC, 32'hC);
    step(1);
    check32("hz_next_pc3", PC, 32'h10);

    // Redirect with latency 3 and two requests in flight
    do_reset(3);
    step(6);
    pcWriteEnable = 1'b1;
    pcWriteData   = 32'h100;
    step(1);
    pcWriteEnable = 1'b0;
    check1("redir_bubble_vld", instrValid, 1'b0);
    check32("redir_bubble_instr", instr, NOP);
    wait_valid(20, "redir_wait");
    check32("redir_pc", PC, 32'h100);
    check32("redir_instr", instr, memf(32'h100));

    // Redirect together with hazard, unaligned target
    hazard        = 1'b1;
    pcWriteEnable = 1'b1;
    pcWriteData   = 32'h203;
    step(1);
    pcWriteEnable = 1'b0;
    check1("redir_hz_vld", instrValid, 1'b0);
    check32("redir_hz_instr", instr, NOP);
    check32("redir_hz_pc_kept", PC, 32'h100);
    step(1);
    hazard = 1'b0;
    wait_valid(20, "redir_hz_wait");
    check32("redir_hz_pc", PC, 32'h200);

    // Back-to-back redirects: the last one wins
    step(2);
    pcWriteEnable = 1'b1;
    pcWriteData   = 32'h300;
    step(1);
    pcWriteData   = 32'h400;
    step(1);
    pcWriteEnable = 1'b0;
    wait_valid(20, "b2b_wait");
    check32("b2b_pc", PC, 32'h400);

    // Mixed traffic with latency 2
    mem_lat = 2;
    for (int i = 0; i < 80; i++) begin
      hazard        = ($urandom_range(0, 3) == 0);
      imemReqReady  = ($urandom_range(0, 2) != 0);
      pcWriteEnable = ($urandom_range(0, 11) == 0);
      pcWriteData   = $urandom;
      step(1);
    end
    hazard        = 1'b0;
    imemReqReady  = 1'b1;
    pcWriteEnable = 1'b0;

    // Asynchronous reset in the middle of a burst
    step(6);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check32("async_rst_pc", PC, RESET_PC);
    check32("async_rst_instr", instr, 32'h0000_0033);
    check1("async_rst_vld", instrValid, 1'b0);
    check1("async_rst_req", imemReqValid, 1'b0);
    step(2);
    reset = 1'b1;
    step(3);
    check32("post_rst_pc", PC, 32'h0);
    check1("post_rst_vld", instrValid, 1'b1);
    step(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
